fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Program-counter and fetch-control FSM driving the instruction ROM address (A bits, W-bit words).
//  Sequences each program run: start, stall, halt and fault handling.
//  Sits between top-level test harness (Start/Done) and decode/branch logic.
//  The ROM read is combinational, so the instruction for InstAddress is valid in the same cycle.
// PARAMETERS
//  A  10  instruction address width; ROM depth 2**A
// PORTS
//  Clk         in   1  single clock, rising edge
//  Reset_n     in   1  reset, asynchronous assert, active-low
//  Start       in   1  one-cycle pulse: begin a run at StartAddr
//  StartAddr   in   A  entry point latched on an accepted Start
//  Stall       in   1  hold PC this cycle (datapath busy)
//  Halt        in   1  decode flags current instruction as halt
//  BranchEn    in   1  take branch/jump this cycle
//  BranchAbs   in   1  1: PC<=Target; 0: PC<=PC+signed(Target)
//  Target      in   A  absolute address or two's-complement offset
//  InstAddress out  A  registered PC to the ROM
//  Fetching    out  1  1 while state==RUN
//  Done        out  1  1 while state==HALT (run complete)
//  Fault       out  1  sticky: PC ran past 2**A-1 in the last run
// BEHAVIOUR
//  Reset (Reset_n=0, any time, mid-run included): state=IDLE, InstAddress=0, Done=0, Fault=0, Fetching=0.
//  States:
//  - IDLE: Start -> RUN; PC<=StartAddr. All other inputs ignored.
//  - RUN: one action per cycle, priority Halt > Stall > BranchEn > increment:
//    . Halt -> HALT; PC holds.
//    . Stall -> PC holds.
//    . BranchEn, BranchAbs=1 -> PC<=Target.
//    . BranchEn, BranchAbs=0 -> PC<=PC+Target, A-bit two's-complement arithmetic, wraps mod 2**A, no fault.
//    . Increment at PC==2**A-1 -> Fault<=1, state HALT, PC holds. No wrap to 0.
//    . Otherwise PC<=PC+1.
//    . Start is ignored while in RUN.
//  - HALT: Done=1, PC holds. Start -> RUN; PC<=StartAddr; Done<=0 and Fault<=0 in the same edge.
//  Latency:
//  - Start -> first InstAddress=StartAddr: 1 cycle. Fetching and Done change on the same edge.
//  - Branch/increment effect: visible the next cycle.
//  - Halt -> Done=1: next cycle.
//  Outputs are registered or decoded from state only. No combinational input-to-output path.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//  - Extra output InstCount [31:0].
//  - Cleared on reset and on accepted Start.
//  - +1 on each RUN cycle that is not Stall and not Halt; saturates at 32'hFFFF_FFFF.
//  - Held through HALT so the bench can read it.
//  FETCH_PERF_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  fetch_pkg: typedef enum logic[1:0] {IDLE, RUN, HALT} fetch_state_t; localparam default A=10.
//  Sub-module pc_next (combinational next-PC mux/adder) is natural.
//  FSM and registers live in fetch_sequencer.
// TESTING
//  1. Reset mid-run: Reset_n low at PC=0x05 -> same cycle InstAddress=0, Fetching=0, Done=0.
//  2. Start, StartAddr=0x010, 3 clean cycles then Halt ->
//     InstAddress 0x010, 0x011, 0x012, 0x013 (held); Done=1 the cycle after Halt.
//  3. Branches: PC=0x020; BranchAbs=1, Target=0x100 -> 0x100;
//     then relative Target=0x3FE (-2) -> 0x0FE;
//     then PC=0x001, Target=0x3FD -> 0x3FE, no fault.
//  4. Priority: Stall+BranchEn at PC=0x040 -> PC stays 0x040;
//     Halt+Stall -> HALT.
//  5. Overflow: Start at 0x3FE, no branches -> 0x3FF, then Fault=1 and Done=1, PC 0x3FF;
//     re-Start at 0x000 clears Fault and Done.
//  6. FETCH_PERF_EN: 4 run cycles + 2 stalls + Halt -> InstCount=4;
//     Start while RUN is ignored (count continues).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// Holds the run-state encoding and the default ROM address width.
package fetch_pkg;

    localparam int FETCH_A_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Next-PC candidates: branch target (absolute or relative) and PC+1.
// Latency: combinational. Backpressure: none; the caller picks which candidate to use.
// at_end flags the last ROM word so the caller can fault instead of wrapping.
module fetch_sequencer_pc_next #(
    parameter int A = fetch_pkg::FETCH_A_DEFAULT
) (
    input  logic [A-1:0] pc,
    input  logic         branch_abs,
    input  logic [A-1:0] target,
    output logic [A-1:0] branch_pc,
    output logic [A-1:0] inc_pc,
    output logic         at_end
);

    localparam logic [A-1:0] ONE = {{(A-1){1'b0}}, 1'b1};

    // A relative branch wraps mod 2**A; an A-bit add gives that for free.
    always_comb begin
        branch_pc = branch_abs ? target : pc + target;
        inc_pc    = pc + ONE;
        at_end    = &pc;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC and fetch-control FSM; optional InstCount perf counter under FETCH_PERF_EN.
// Latency: Start, branch and increment are visible on InstAddress one cycle later.
// Backpressure: Stall holds the PC for the cycle; Halt ends the run with Done one cycle later.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int A = FETCH_A_DEFAULT
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [A-1:0] StartAddr,
    input  logic         Stall,
    input  logic         Halt,
    input  logic         BranchEn,
    input  logic         BranchAbs,
    input  logic [A-1:0] Target,
    output logic [A-1:0] InstAddress,
`ifdef FETCH_PERF_EN
    output logic [31:0]  InstCount,
`endif
    output logic         Fetching,
    output logic         Done,
    output logic         Fault
);

    fetch_state_t state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic         fault_q, fault_d;
    logic [A-1:0] branch_pc;
    logic [A-1:0] inc_pc;
    logic         at_end;
    logic         advance;

    fetch_sequencer_pc_next #(.A(A)) u_pc_next (
        .pc        (pc_q),
        .branch_abs(BranchAbs),
        .target    (Target),
        .branch_pc (branch_pc),
        .inc_pc    (inc_pc),
        .at_end    (at_end)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = StartAddr;
                end
            end
            RUN: begin
                if (Halt) begin
                    state_d = HALT;
                end else if (!Stall) begin
                    advance = 1'b1;
                    if (BranchEn) begin
                        pc_d = branch_pc;
                    end else if (at_end) begin
                        // Running off the end of the ROM stops the run rather than wrapping.
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d = inc_pc;
                    end
                end
            end
            HALT: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = StartAddr;
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] count_q, count_d;
    logic        start_acc;

    assign start_acc = Start && (state_q != RUN);

    always_comb begin
        count_d = count_q;
        if (start_acc) begin
            count_d = '0;
        end else if (advance && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign InstCount = count_q;
`endif

    assign InstAddress = pc_q;
    assign Fetching    = (state_q == RUN);
    assign Done        = (state_q == HALT);
    assign Fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

    localparam int A = 10;

    logic         Clk;
    logic         Reset_n;
    logic         Start;
    logic [A-1:0] StartAddr;
    logic         Stall;
    logic         Halt;
    logic         BranchEn;
    logic         BranchAbs;
    logic [A-1:0] Target;
    logic [A-1:0] InstAddress;
    logic         Fetching;
    logic         Done;
    logic         Fault;
`ifdef FETCH_PERF_EN
    logic [31:0]  InstCount;
`endif

    int n_vec = 0;
    int n_err = 0;

    fetch_sequencer #(.A(A)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Stall      (Stall),
        .Halt       (Halt),
        .BranchEn   (BranchEn),
        .BranchAbs  (BranchAbs),
        .Target     (Target),
        .InstAddress(InstAddress),
`ifdef FETCH_PERF_EN
        .InstCount  (InstCount),
`endif
        .Fetching   (Fetching),
        .Done       (Done),
        .Fault      (Fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [A-1:0] pc, input logic fe,
                            input logic dn, input logic ft);
        check({tag, "_pc"}, 32'(InstAddress), 32'(pc));
        check({tag, "_fetching"}, 32'(Fetching), 32'(fe));
        check({tag, "_done"}, 32'(Done), 32'(dn));
        check({tag, "_fault"}, 32'(Fault), 32'(ft));
    endtask

    initial begin
        Reset_n   = 1'b0;
        Start     = 1'b0;
        StartAddr = '0;
        Stall     = 1'b0;
        Halt      = 1'b0;
        BranchEn  = 1'b0;
        BranchAbs = 1'b0;
        Target    = '0;
        #1;
        check_st("reset", 10'h000, 1'b0, 1'b0, 1'b0);
        step();
        step();
        Reset_n = 1'b1;
        step();
        check_st("idle", 10'h000, 1'b0, 1'b0, 1'b0);

        // Linear run from 0x010, then halt at 0x013
        Start = 1'b1; StartAddr = 10'h010;
        step();
        Start = 1'b0; StartAddr = 10'h3AA;
        check_st("start010", 10'h010, 1'b1, 1'b0, 1'b0);
        step(); check("inc1", 32'(InstAddress), 32'h011);
        step(); check("inc2", 32'(InstAddress), 32'h012);
        step(); check("inc3", 32'(InstAddress), 32'h013);
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        check_st("halt", 10'h013, 1'b0, 1'b1, 1'b0);
        step();
        check_st("halt_hold", 10'h013, 1'b0, 1'b1, 1'b0);

        // Branches
        Start = 1'b1; StartAddr = 10'h020;
        step();
        Start = 1'b0;
        check_st("start020", 10'h020, 1'b1, 1'b0, 1'b0);
        BranchEn = 1'b1; BranchAbs = 1'b1; Target = 10'h100;
        step(); check("br_abs", 32'(InstAddress), 32'h100);
        BranchAbs = 1'b0; Target = 10'h3FE;
        step(); check("br_rel_m2", 32'(InstAddress), 32'h0FE);
        BranchAbs = 1'b1; Target = 10'h001;
        step(); check("br_abs1", 32'(InstAddress), 32'h001);
        BranchAbs = 1'b0; Target = 10'h3FD;
        step();
        check_st("br_rel_wrap", 10'h3FE, 1'b1, 1'b0, 1'b0);
        BranchEn = 1'b0;

        // Start is ignored during RUN; then increment past the end faults
        Start = 1'b1; StartAddr = 10'h200;
        step();
        Start = 1'b0;
        check_st("start_in_run", 10'h3FF, 1'b1, 1'b0, 1'b0);
        step();
        check_st("overflow", 10'h3FF, 1'b0, 1'b1, 1'b1);

        // Priority: Stall beats BranchEn, Halt beats Stall
        Start = 1'b1; StartAddr = 10'h040;
        step();
        Start = 1'b0;
        check_st("restart040", 10'h040, 1'b1, 1'b0, 1'b0);
        Stall = 1'b1; BranchEn = 1'b1; BranchAbs = 1'b1; Target = 10'h123;
        step(); check("stall_br", 32'(InstAddress), 32'h040);
        Stall = 1'b0; BranchEn = 1'b0;
        step(); check("after_stall", 32'(InstAddress), 32'h041);
        Halt = 1'b1; Stall = 1'b1;
        step();
        Halt = 1'b0; Stall = 1'b0;
        check_st("halt_stall", 10'h041, 1'b0, 1'b1, 1'b0);

        // Overflow from 0x3FE without branches, then re-Start clears Fault/Done
        Start = 1'b1; StartAddr = 10'h3FE;
        step();
        Start = 1'b0;
        check_st("start3fe", 10'h3FE, 1'b1, 1'b0, 1'b0);
        step();
        check_st("at3ff", 10'h3FF, 1'b1, 1'b0, 1'b0);
        step();
        check_st("fault", 10'h3FF, 1'b0, 1'b1, 1'b1);
        step();
        check_st("fault_hold", 10'h3FF, 1'b0, 1'b1, 1'b1);
        Start = 1'b1; StartAddr = 10'h000;
        step();
        Start = 1'b0;
        check_st("clear_fault", 10'h000, 1'b1, 1'b0, 1'b0);

        // 4 run cycles + 2 stalls + Halt
`ifdef FETCH_PERF_EN
        check("cnt_clear", InstCount, 32'd0);
`endif
        for (int i = 0; i < 4; i++) step();
        check("run4", 32'(InstAddress), 32'h004);
        Stall = 1'b1;
        step();
        step();
        Stall = 1'b0;
        check("stall2", 32'(InstAddress), 32'h004);
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        check_st("perf_halt", 10'h004, 1'b0, 1'b1, 1'b0);
`ifdef FETCH_PERF_EN
        check("cnt4", InstCount, 32'd4);
        step();
        check("cnt4_hold", InstCount, 32'd4);
`endif
        Start = 1'b1; StartAddr = 10'h000;
        step();
        Start = 1'b0;
        step();
        step();
        Start = 1'b1; StartAddr = 10'h300;
        step();
        Start = 1'b0;
        check("ign_start_pc", 32'(InstAddress), 32'h003);
`ifdef FETCH_PERF_EN
        check("cnt_ign_start", InstCount, 32'd3);
`endif

        // Asynchronous reset mid-run at PC 0x005
        Start = 1'b1; StartAddr = 10'h005;
        step();
        Start = 1'b0;
        check("at005", 32'(InstAddress), 32'h003 + 32'h001);
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        Start = 1'b1; StartAddr = 10'h005;
        step();
        Start = 1'b0;
        check_st("run005", 10'h005, 1'b1, 1'b0, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        check_st("async_rst", 10'h000, 1'b0, 1'b0, 1'b0);
        step();
        Reset_n = 1'b1;
        step();
        check_st("post_rst_idle", 10'h000, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
        check("cnt_rst", InstCount, 32'd0);
`endif
        Start = 1'b1; StartAddr = 10'h007;
        step();
        Start = 1'b0;
        check_st("post_rst_start", 10'h007, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
